// File: rtl/alu_arbiter_if.sv
// Request/response bundle between the two requesting units and alu_arbiter.
// Port 0 and port 1 share one bus: bit i of every 2-bit vector belongs to port i.
interface alu_arbiter_if #(
  parameter int WIDTH = 32
);
  logic [1:0]       req_valid;
  logic [1:0]       req_ready;
  logic [WIDTH-1:0] req_a0;
  logic [WIDTH-1:0] req_b0;
  logic [WIDTH-1:0] req_a1;
  logic [WIDTH-1:0] req_b1;
  logic [2:0]       req_op0;
  logic [2:0]       req_op1;
  logic [1:0]       rsp_valid;
  logic [1:0]       rsp_ready;
  logic [WIDTH-1:0] rsp_data;
  logic             rsp_err;

  // Requesting units: drive requests, consume responses.
  modport master (
    output req_valid, req_a0, req_b0, req_a1, req_b1, req_op0, req_op1, rsp_ready,
    input  req_ready, rsp_valid, rsp_data, rsp_err
  );

  // Arbiter side.
  modport slave (
    input  req_valid, req_a0, req_b0, req_a1, req_b1, req_op0, req_op1, rsp_ready,
    output req_ready, rsp_valid, rsp_data, rsp_err
  );
endinterface

// File: rtl/alu_arbiter.sv
// Round-robin sharing of one combinational ALU between two requesters.
// Each operation walks IDLE -> EXEC -> RESP; the ALU operands and control are
// registered and only non-zero during EXEC, the result is registered for RESP.
module alu_arbiter #(
  parameter int WIDTH = 32,
  parameter int CNT_W = 16
) (
  input  logic              clk,
  input  logic              reset,
  alu_arbiter_if.slave      bus,
  output logic [WIDTH-1:0]  alu_src_a,
  output logic [WIDTH-1:0]  alu_src_b,
  output logic [2:0]        alu_ctrl,
  input  logic [WIDTH-1:0]  alu_result,
  output logic              busy,
  output logic [CNT_W-1:0]  done_count
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } state_t;

  // Highest legal opcode (slt); 101..111 are illegal.
  localparam logic [2:0] OP_MAX = 3'b100;

  state_t           state;
  state_t           state_next;
  logic             last_grant;
  logic             grant;
  logic             port;
  logic             op_err;
  logic             accept;
  logic             complete;
  logic [WIDTH-1:0] sel_a;
  logic [WIDTH-1:0] sel_b;
  logic [2:0]       sel_op;
  logic [WIDTH-1:0] result_q;
  logic             err_q;

  // Round-robin pick: a lone requester wins, a tie goes to the port not served last.
  always_comb begin
    // NOTE: every signal written in always_comb gets a default first so no path can infer a latch.
    grant = 1'b0;
    unique case (bus.req_valid)
      2'b01:   grant = 1'b0;
      2'b10:   grant = 1'b1;
      2'b11:   grant = ~last_grant;
      default: grant = 1'b0;
    endcase
  end

  assign sel_a  = grant ? bus.req_a1  : bus.req_a0;
  assign sel_b  = grant ? bus.req_b1  : bus.req_b0;
  assign sel_op = grant ? bus.req_op1 : bus.req_op0;

  // Reset dominates a coincident request: no handshake is offered while reset is high.
  assign accept   = (state == IDLE) && !reset && (bus.req_valid != 2'b00);
  assign complete = (state == RESP) && bus.rsp_ready[port];
  assign busy     = (state != IDLE);

  // State register.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    if (reset) state <= IDLE;
    else       state <= state_next;
  end

  // Next-state logic and handshake outputs.
  always_comb begin
    state_next    = state;
    bus.req_ready = 2'b00;
    bus.rsp_valid = 2'b00;
    unique case (state)
      IDLE: begin
        if (accept) begin
          bus.req_ready[grant] = 1'b1;
          state_next           = EXEC;
        end
      end
      EXEC: state_next = RESP;
      RESP: begin
        bus.rsp_valid[port] = 1'b1;
        if (bus.rsp_ready[port]) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // Request latch, ALU drive, result capture and completion counter.
  always_ff @(posedge clk) begin
    // NOTE: all data registers are reset because their reset values are visible on the outputs.
    if (reset) begin
      last_grant <= 1'b1;
      port       <= 1'b0;
      op_err     <= 1'b0;
      alu_src_a  <= '0;
      alu_src_b  <= '0;
      alu_ctrl   <= 3'b000;
      result_q   <= '0;
      err_q      <= 1'b0;
      done_count <= '0;
    end else begin
      if (accept) begin
        last_grant <= grant;
        port       <= grant;
        op_err     <= (sel_op > OP_MAX);
        alu_src_a  <= sel_a;
        alu_src_b  <= sel_b;
        // An illegal opcode is presented to the ALU as a harmless add.
        alu_ctrl   <= (sel_op > OP_MAX) ? 3'b000 : sel_op;
      end
      if (state == EXEC) begin
        result_q  <= op_err ? '0 : alu_result;
        err_q     <= op_err;
        alu_src_a <= '0;
        alu_src_b <= '0;
        alu_ctrl  <= 3'b000;
      end
      if (complete && (done_count != '1)) begin
        done_count <= done_count + CNT_W'(1);
      end
    end
  end

  assign bus.rsp_data = result_q;
  assign bus.rsp_err  = err_q;

endmodule

// File: tb/tb_alu_arbiter.sv
// Bench for alu_arbiter: an external ALU, a transaction-level reference
// (who should win, what the answer is, how many completions) and scenario tasks.
module tb_alu_arbiter;
  localparam int WIDTH = 32;
  localparam int CNT_W = 4;   // small counter so saturation is reachable

  logic             clk = 1'b0;
  logic             reset = 1'b1;
  logic [WIDTH-1:0] alu_src_a, alu_src_b, alu_result;
  logic [2:0]       alu_ctrl;
  logic             busy;
  logic [CNT_W-1:0] done_count;

  always #5 clk = ~clk;

  alu_arbiter_if #(.WIDTH(WIDTH)) bus ();

  alu_arbiter #(.WIDTH(WIDTH), .CNT_W(CNT_W)) dut (
    .clk        (clk),
    .reset      (reset),
    .bus        (bus),
    .alu_src_a  (alu_src_a),
    .alu_src_b  (alu_src_b),
    .alu_ctrl   (alu_ctrl),
    .alu_result (alu_result),
    .busy       (busy),
    .done_count (done_count)
  );

  // The datapath ALU the arbiter is attached to.
  always_comb begin
    case (alu_ctrl)
      3'b000:  alu_result = alu_src_a + alu_src_b;
      3'b001:  alu_result = alu_src_a - alu_src_b;
      3'b010:  alu_result = alu_src_a & alu_src_b;
      3'b011:  alu_result = alu_src_a | alu_src_b;
      3'b100:  alu_result = (alu_src_a < alu_src_b) ? 32'd1 : 32'd0;
      default: alu_result = 32'hDEAD_BEEF;
    endcase
  end

  int          n_checks = 0;
  int          n_pass   = 0;
  logic [1:0]  pend_valid;
  logic [2:0]  pend_op [2];
  logic [31:0] pend_a  [2];
  logic [31:0] pend_b  [2];
  logic        model_last;
  int          model_count;

  function automatic void ref_alu(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                                  output logic [31:0] r, output logic e);
    e = 1'b0;
    case (op)
      3'd0:    r = a + b;
      3'd1:    r = a - b;
      3'd2:    r = a & b;
      3'd3:    r = a | b;
      3'd4:    r = (a < b) ? 32'd1 : 32'd0;
      default: begin r = 32'd0; e = 1'b1; end
    endcase
  endfunction

  task automatic drive();
    bus.req_valid = pend_valid;
    bus.req_op0   = pend_op[0];
    bus.req_a0    = pend_a[0];
    bus.req_b0    = pend_b[0];
    bus.req_op1   = pend_op[1];
    bus.req_a1    = pend_a[1];
    bus.req_b1    = pend_b[1];
  endtask

  task automatic set_req(input int p, input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    pend_valid[p] = 1'b1;
    pend_op[p]    = op;
    pend_a[p]     = a;
    pend_b[p]     = b;
  endtask

  task automatic do_reset();
    reset         = 1'b1;
    pend_valid    = 2'b00;
    bus.rsp_ready = 2'b00;
    drive();
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset       = 1'b0;
    model_last  = 1'b1;
    model_count = 0;
  endtask

  // One full transaction for the currently presented requests. `hold` cycles of
  // response back-pressure (other port's rsp_ready high meanwhile); `late` ports
  // raise their (preset) request right after the handshake.
  task automatic step_op(input int hold, input logic [1:0] late);
    int          w;
    logic [1:0]  oh;
    logic [31:0] exp_d;
    logic        exp_e;
    logic [2:0]  exp_ctrl;
    drive();
    #1;
    if (pend_valid == 2'b00) begin
      n_checks++;
      $display("FAIL step_op: no request presented, got none, required one");
      return;
    end
    w  = (pend_valid == 2'b11) ? int'(!model_last) : int'(pend_valid[1]);
    oh = 2'b01 << w;
    ref_alu(pend_op[w], pend_a[w], pend_b[w], exp_d, exp_e);
    exp_ctrl = exp_e ? 3'b000 : pend_op[w];

    n_checks++;
    if ({busy, bus.req_ready, bus.rsp_valid, alu_ctrl} !== {1'b0, oh, 2'b00, 3'b000})
      $display("FAIL grant: got busy=%b req_ready=%b rsp_valid=%b ctrl=%b, required busy=0 req_ready=%b rsp_valid=00 ctrl=000",
               busy, bus.req_ready, bus.rsp_valid, alu_ctrl, oh);
    else n_pass++;

    @(posedge clk);
    model_last    = w[0];
    pend_valid[w] = 1'b0;
    pend_valid    = pend_valid | late;
    @(negedge clk);
    drive();
    #1;
    n_checks++;
    if ({busy, bus.req_ready, bus.rsp_valid, alu_ctrl, alu_src_a, alu_src_b} !==
        {1'b1, 2'b00, 2'b00, exp_ctrl, pend_a[w], pend_b[w]})
      $display("FAIL exec: got busy=%b ready=%b rsp_valid=%b ctrl=%b a=%h b=%h, required busy=1 ready=00 rsp_valid=00 ctrl=%b a=%h b=%h",
               busy, bus.req_ready, bus.rsp_valid, alu_ctrl, alu_src_a, alu_src_b, exp_ctrl, pend_a[w], pend_b[w]);
    else n_pass++;

    @(negedge clk);
    for (int i = 0; i <= hold; i++) begin
      bus.rsp_ready = (i == hold) ? oh : ~oh;
      #1;
      n_checks++;
      if ({busy, bus.req_ready, bus.rsp_valid, bus.rsp_data, bus.rsp_err, alu_ctrl, alu_src_a, alu_src_b} !==
          {1'b1, 2'b00, oh, exp_d, exp_e, 3'b000, 32'd0, 32'd0})
        $display("FAIL resp[%0d]: got busy=%b ready=%b rsp_valid=%b data=%h err=%b ctrl=%b a=%h b=%h, required busy=1 ready=00 rsp_valid=%b data=%h err=%b alu=0",
                 i, busy, bus.req_ready, bus.rsp_valid, bus.rsp_data, bus.rsp_err, alu_ctrl, alu_src_a, alu_src_b,
                 oh, exp_d, exp_e);
      else n_pass++;
      if (i < hold) @(negedge clk);
    end

    @(posedge clk);
    model_count = (model_count == (2 ** CNT_W) - 1) ? model_count : model_count + 1;
    @(negedge clk);
    bus.rsp_ready = 2'b00;
    #1;
    n_checks++;
    if ({busy, bus.rsp_valid, done_count} !== {1'b0, 2'b00, CNT_W'(model_count)})
      $display("FAIL done: got busy=%b rsp_valid=%b done_count=%0d, required busy=0 rsp_valid=00 done_count=%0d",
               busy, bus.rsp_valid, done_count, model_count);
    else n_pass++;
  endtask

  task automatic test_reset();
    do_reset();
    #1;
    n_checks++;
    if ({busy, bus.req_ready, bus.rsp_valid, bus.rsp_data, bus.rsp_err, alu_ctrl, alu_src_a, alu_src_b, done_count} !== '0)
      $display("FAIL reset_values: got busy=%b ready=%b rsp_valid=%b data=%h err=%b ctrl=%b a=%h b=%h cnt=%0d, required all 0",
               busy, bus.req_ready, bus.rsp_valid, bus.rsp_data, bus.rsp_err, alu_ctrl, alu_src_a, alu_src_b, done_count);
    else n_pass++;
    // Reset coinciding with requests: no handshake.
    reset = 1'b1;
    set_req(0, 3'd0, 32'd1, 32'd2);
    set_req(1, 3'd0, 32'd3, 32'd4);
    drive();
    #1;
    n_checks++;
    if (bus.req_ready !== 2'b00)
      $display("FAIL reset_dominates: got req_ready=%b, required 00", bus.req_ready);
    else n_pass++;
    @(posedge clk);
    @(negedge clk);
    reset      = 1'b0;
    pend_valid = 2'b00;
    drive();
    #1;
    n_checks++;
    if ({busy, alu_ctrl, alu_src_a} !== '0)
      $display("FAIL reset_no_issue: got busy=%b ctrl=%b a=%h, required 0", busy, alu_ctrl, alu_src_a);
    else n_pass++;
  endtask

  task automatic test_single_add();
    set_req(0, 3'd0, 32'd5, 32'd7);
    step_op(0, 2'b00);
  endtask

  task automatic test_back_to_back();
    do_reset();
    for (int k = 0; k < 4; k++) begin
      set_req(0, 3'd1, 32'd3, 32'd5);
      set_req(1, 3'd3, 32'h0000_00F0, 32'h0000_000F);
      step_op(0, 2'b00);
    end
    pend_valid = 2'b00;
  endtask

  task automatic test_slt();
    set_req(1, 3'd4, 32'd2, 32'd9);
    step_op(0, 2'b00);
    set_req(1, 3'd4, 32'd9, 32'd2);
    step_op(0, 2'b00);
  endtask

  task automatic test_illegal();
    set_req(0, 3'b110, 32'd1234, 32'd5);
    step_op(0, 2'b00);
  endtask

  task automatic test_backpressure();
    set_req(0, 3'd0, 32'h1234_5678, 32'h1111_1111);
    pend_op[1] = 3'd2;
    pend_a[1]  = 32'hF0F0_F0F0;
    pend_b[1]  = 32'hFF00_FF00;
    step_op(10, 2'b10);
    step_op(0, 2'b00);
  endtask

  task automatic test_reset_exec();
    set_req(0, 3'd0, 32'd10, 32'd20);
    step_op(0, 2'b00);
    set_req(1, 3'd1, 32'd7, 32'd3);
    drive();
    @(posedge clk);
    pend_valid = 2'b00;
    @(negedge clk);
    drive();
    #1;
    n_checks++;
    if ({busy, alu_ctrl} !== {1'b1, 3'b001})
      $display("FAIL reset_exec_pre: got busy=%b ctrl=%b, required busy=1 ctrl=001", busy, alu_ctrl);
    else n_pass++;
    reset = 1'b1;
    @(posedge clk);
    @(negedge clk);
    reset       = 1'b0;
    model_last  = 1'b1;
    model_count = 0;
    #1;
    n_checks++;
    if ({busy, bus.rsp_valid, done_count, alu_ctrl, alu_src_a, bus.rsp_data} !== '0)
      $display("FAIL reset_exec_post: got busy=%b rsp_valid=%b cnt=%0d ctrl=%b a=%h data=%h, required all 0",
               busy, bus.rsp_valid, done_count, alu_ctrl, alu_src_a, bus.rsp_data);
    else n_pass++;
    repeat (3) @(negedge clk);
    #1;
    n_checks++;
    if ({busy, bus.rsp_valid} !== 3'b000)
      $display("FAIL reset_exec_dropped: got busy=%b rsp_valid=%b, required 0 00", busy, bus.rsp_valid);
    else n_pass++;
  endtask

  function automatic logic [31:0] rand_operand();
    case ($urandom_range(0, 3))
      0:       return 32'd0;
      1:       return 32'hFFFF_FFFF;
      2:       return 32'h8000_0000;
      default: return $urandom;
    endcase
  endfunction

  task automatic test_random();
    for (int k = 0; k < 40; k++) begin
      for (int p = 0; p < 2; p++) begin
        if (!pend_valid[p] && ($urandom_range(0, 2) != 0))
          set_req(p, 3'($urandom_range(0, 7)), rand_operand(), rand_operand());
      end
      if (pend_valid == 2'b00)
        set_req(int'($urandom_range(0, 1)), 3'($urandom_range(0, 7)), rand_operand(), rand_operand());
      step_op(int'($urandom_range(0, 3)), 2'b00);
    end
  endtask

  initial begin
    for (int p = 0; p < 2; p++) begin
      pend_op[p] = 3'd0;
      pend_a[p]  = 32'd0;
      pend_b[p]  = 32'd0;
    end
    pend_valid    = 2'b00;
    bus.rsp_ready = 2'b00;
    model_last    = 1'b1;
    model_count   = 0;
    drive();
    test_reset();
    test_single_add();
    test_back_to_back();
    test_slt();
    test_illegal();
    test_backpressure();
    test_reset_exec();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
